// File: rtl/te_ingress_decoder_pkg.sv
// Shared types for the trace-encoder ingress path: beat and decoded-block layouts,
// itype codes and the serialiser state encoding.
package te_ingress_decoder_pkg;

   localparam int unsigned NL          = 2;
   localparam int unsigned XLEN        = 32;
   localparam int unsigned IRETIRE_LEN = 7;
   localparam int unsigned ITYPE_LEN   = 3;
   localparam int unsigned PRIV_LEN    = 2;

   localparam logic [ITYPE_LEN-1:0] ITYPE_NONE  = 3'd0;
   localparam logic [ITYPE_LEN-1:0] ITYPE_EXC   = 3'd1;
   localparam logic [ITYPE_LEN-1:0] ITYPE_INT   = 3'd2;
   localparam logic [ITYPE_LEN-1:0] ITYPE_RET   = 3'd3;
   localparam logic [ITYPE_LEN-1:0] ITYPE_NTBR  = 3'd4;
   localparam logic [ITYPE_LEN-1:0] ITYPE_TBR   = 3'd5;
   localparam logic [ITYPE_LEN-1:0] ITYPE_UJUMP = 3'd6;

   typedef struct packed {
      logic [NL-1:0]                  valid;
      logic [NL-1:0][IRETIRE_LEN-1:0] iretire;
      logic [NL-1:0]                  ilastsize;
      logic [NL-1:0][ITYPE_LEN-1:0]   itype;
      logic [NL-1:0][XLEN-1:0]        iaddr;
      logic [XLEN-1:0]                cause;
      logic [XLEN-1:0]                tval;
      logic [PRIV_LEN-1:0]            priv;
   } te_beat_s;

   typedef struct packed {
      logic [XLEN-1:0]      start;
      logic [XLEN-1:0]      last;
      logic [XLEN-1:0]      next;
      logic [ITYPE_LEN-1:0] itype;
      logic [XLEN-1:0]      cause;
      logic [XLEN-1:0]      tval;
      logic [PRIV_LEN-1:0]  priv;
      logic                 empty;
   } te_blk_s;

   localparam int unsigned BLK_W = $bits(te_blk_s);

   typedef enum logic {S_IDLE, S_EMIT} ser_state_e;

   // Only fall-through blocks promise that the next block starts at their end address.
   function automatic logic is_sequential(input logic [ITYPE_LEN-1:0] itype);
      return (itype == ITYPE_NONE) || (itype == ITYPE_NTBR);
   endfunction

endpackage

// File: rtl/te_ingress_decoder_fifo.sv
// Beat buffer with synchronous active-high reset; a push into a full buffer is
// accepted when the head is popped in the same cycle.
module te_beat_fifo
   import te_ingress_decoder_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       push_i,
   input  te_beat_s   data_i,
   input  logic       pop_i,
   output te_beat_s   data_o,
   output logic       full_o,
   output logic       empty_o,
   output logic [AW:0] usage_o
);

   te_beat_s      mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [AW:0]   cnt;
   logic          do_push, do_pop;

   assign full_o  = (cnt == (AW+1)'(DEPTH));
   assign empty_o = (cnt == '0);
   assign usage_o = cnt;
   assign data_o  = mem[rptr];
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem[wptr] <= data_i;
   end

endmodule

// File: rtl/te_ingress_decoder.sv
// Receiver side of the trace-encoder ingress: buffers N-lane beats, serialises them into
// one decoded block per handshake, and tracks PC continuity plus sticky debug flags.
module te_ingress_decoder
   import te_ingress_decoder_pkg::*;
#(
   parameter int unsigned N          = NL,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     clear_i,
   input  logic [N-1:0]             valid_i,
   input  logic [N*IRETIRE_LEN-1:0] iretire_i,
   input  logic [N-1:0]             ilastsize_i,
   input  logic [N*ITYPE_LEN-1:0]   itype_i,
   input  logic [N*XLEN-1:0]        iaddr_i,
   input  logic [XLEN-1:0]          cause_i,
   input  logic [XLEN-1:0]          tval_i,
   input  logic [PRIV_LEN-1:0]      priv_i,
   output logic                     blk_valid_o,
   input  logic                     blk_ready_i,
   output logic [BLK_W-1:0]         blk_o,
   output logic                     seq_err_o,
   output logic                     overflow_o,
   output logic [31:0]              blk_cnt_o
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   te_beat_s   beat_in, head;
   te_blk_s    blk;
   ser_state_e state, state_nxt;
   logic              fifo_full, fifo_empty;
   logic [AW:0]       fifo_usage;
   logic [N-1:0]      consumed, remaining, cur_oh;
   logic              push_req, push_acc, drop, hs, last_lane, pop, seq_mis;
   logic [XLEN-1:0]   sel_addr, ret_bytes, trk_next;
   logic [IRETIRE_LEN-1:0] sel_ret;
   logic              sel_ls, trk_vld;
   logic [ITYPE_LEN-1:0] sel_type, trk_itype;

   always_comb begin
      beat_in       = '0;
      beat_in.valid = valid_i;
      beat_in.cause = cause_i;
      beat_in.tval  = tval_i;
      beat_in.priv  = priv_i;
      for (int i = 0; i < N; i++) begin
         beat_in.iretire[i]   = iretire_i[i*IRETIRE_LEN +: IRETIRE_LEN];
         beat_in.ilastsize[i] = ilastsize_i[i];
         beat_in.itype[i]     = itype_i[i*ITYPE_LEN +: ITYPE_LEN];
         beat_in.iaddr[i]     = iaddr_i[i*XLEN +: XLEN];
      end
   end

   assign push_req = |valid_i;
   assign push_acc = push_req && (!fifo_full || pop);
   assign drop     = push_req && fifo_full && !pop;

   te_beat_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push_req),
      .data_i  (beat_in),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .usage_o (fifo_usage)
   );

   // Lowest unconsumed valid lane, isolated as a one-hot; invalid lanes cost no cycles.
   assign remaining = head.valid & ~consumed;
   assign cur_oh    = remaining & (-remaining);
   assign last_lane = ((remaining & ~cur_oh) == '0);
   assign hs        = blk_valid_o && blk_ready_i;
   assign pop       = hs && last_lane;

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (push_acc) state_nxt = S_EMIT;
         S_EMIT:  if (pop && fifo_usage == (AW+1)'(1) && !push_acc) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      blk_valid_o = (state == S_EMIT);
      blk_o       = blk_valid_o ? blk : '0;
   end

   always_comb begin
      sel_addr = '0;
      sel_ret  = '0;
      sel_ls   = 1'b0;
      sel_type = '0;
      for (int i = 0; i < N; i++) begin
         if (cur_oh[i]) begin
            sel_addr = head.iaddr[i];
            sel_ret  = head.iretire[i];
            sel_ls   = head.ilastsize[i];
            sel_type = head.itype[i];
         end
      end
      ret_bytes                  = '0;
      ret_bytes[IRETIRE_LEN:0]   = {sel_ret, 1'b0};
      blk       = '0;
      blk.start = sel_addr;
      blk.next  = sel_addr + ret_bytes;
      blk.empty = (sel_ret == '0);
      blk.last  = blk.empty ? sel_addr : blk.next - (sel_ls ? XLEN'(4) : XLEN'(2));
      blk.itype = sel_type;
      blk.priv  = head.priv;
      if (sel_type == ITYPE_EXC || sel_type == ITYPE_INT) begin
         blk.cause = head.cause;
         blk.tval  = head.tval;
      end
   end

   assign seq_mis = hs && !blk.empty && trk_vld && is_sequential(trk_itype) &&
                    (blk.start != trk_next);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         consumed   <= '0;
         trk_vld    <= 1'b0;
         trk_next   <= '0;
         trk_itype  <= '0;
         seq_err_o  <= 1'b0;
         overflow_o <= 1'b0;
         blk_cnt_o  <= '0;
      end else begin
         if (hs) consumed <= pop ? '0 : (consumed | cur_oh);
         if (hs && !blk.empty) begin
            trk_next  <= blk.next;
            trk_itype <= blk.itype;
            trk_vld   <= 1'b1;
         end
         // A dropped beat breaks the block stream, so the next check would be meaningless.
         if (drop) trk_vld <= 1'b0;
         if (seq_mis)      seq_err_o <= 1'b1;
         else if (clear_i) seq_err_o <= 1'b0;
         if (drop)         overflow_o <= 1'b1;
         else if (clear_i) overflow_o <= 1'b0;
         if (clear_i) blk_cnt_o <= '0;
         else if (hs) blk_cnt_o <= blk_cnt_o + 1'b1;
      end
   end

endmodule

// File: tb/tb_te_ingress_decoder.sv
// Directed self-checking bench for te_ingress_decoder.
module tb_te_ingress_decoder;
   import te_ingress_decoder_pkg::*;

   localparam int unsigned N = 2;
   localparam int unsigned D = 8;

   logic                     clk = 1'b0;
   logic                     rst_i = 1'b1, clear_i = 1'b0, blk_ready_i = 1'b0;
   logic [N-1:0]             valid_i = '0, ilastsize_i = '0;
   logic [N*IRETIRE_LEN-1:0] iretire_i = '0;
   logic [N*ITYPE_LEN-1:0]   itype_i = '0;
   logic [N*XLEN-1:0]        iaddr_i = '0;
   logic [XLEN-1:0]          cause_i = '0, tval_i = '0;
   logic [PRIV_LEN-1:0]      priv_i = '0;
   logic                     blk_valid_o, seq_err_o, overflow_o;
   logic [BLK_W-1:0]         blk_o;
   logic [31:0]              blk_cnt_o;
   te_blk_s                  blk;
   int                       n_chk = 0, n_fail = 0;

   assign blk = te_blk_s'(blk_o);

   te_ingress_decoder #(.N(N), .FIFO_DEPTH(D)) dut (
      .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .valid_i(valid_i),
      .iretire_i(iretire_i), .ilastsize_i(ilastsize_i), .itype_i(itype_i),
      .iaddr_i(iaddr_i), .cause_i(cause_i), .tval_i(tval_i), .priv_i(priv_i),
      .blk_valid_o(blk_valid_o), .blk_ready_i(blk_ready_i), .blk_o(blk_o),
      .seq_err_o(seq_err_o), .overflow_o(overflow_o), .blk_cnt_o(blk_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lane(input int l, input logic [31:0] a, input logic [6:0] r,
                           input logic ls, input logic [2:0] t);
      iaddr_i[l*XLEN +: XLEN]               = a;
      iretire_i[l*IRETIRE_LEN +: IRETIRE_LEN] = r;
      ilastsize_i[l]                        = ls;
      itype_i[l*ITYPE_LEN +: ITYPE_LEN]     = t;
   endtask

   task automatic push_one(input logic [31:0] a, input logic [6:0] r,
                           input logic ls, input logic [2:0] t);
      set_lane(0, a, r, ls, t);
      valid_i = 2'b01;
      tick();
      valid_i = '0;
   endtask

   task automatic do_reset();
      valid_i = '0; clear_i = 1'b0; blk_ready_i = 1'b0;
      cause_i = '0; tval_i = '0;
      rst_i = 1'b1;
      tick(); tick();
      rst_i = 1'b0;
   endtask

   task automatic test_reset();
      tick(); tick();
      n_chk++;
      if ({blk_valid_o, seq_err_o, overflow_o, blk_cnt_o, blk_o} !== '0) begin
         n_fail++; $display("FAIL reset_in: outputs %h want 0", {blk_valid_o, seq_err_o, overflow_o, blk_cnt_o, blk_o});
      end
      rst_i = 1'b0;
      tick();
      n_chk++;
      if ({blk_valid_o, seq_err_o, overflow_o, blk_cnt_o} !== '0) begin
         n_fail++; $display("FAIL reset_out: outputs %h want 0", {blk_valid_o, seq_err_o, overflow_o, blk_cnt_o});
      end
   endtask

   task automatic test_single();
      do_reset();
      blk_ready_i = 1'b1;
      push_one(32'h8000_0000, 7'd3, 1'b1, ITYPE_NONE);
      n_chk++;
      if (!blk_valid_o || blk.start !== 32'h8000_0000 || blk.next !== 32'h8000_0006 ||
          blk.last !== 32'h8000_0002 || blk.empty !== 1'b0) begin
         n_fail++; $display("FAIL single_blk: v=%b s=%h n=%h l=%h e=%b want 1/80000000/80000006/80000002/0",
                            blk_valid_o, blk.start, blk.next, blk.last, blk.empty);
      end
      tick();
      n_chk++;
      if (blk_valid_o !== 1'b0 || blk_cnt_o !== 32'd1) begin
         n_fail++; $display("FAIL single_after: v=%b cnt=%0d want 0/1", blk_valid_o, blk_cnt_o);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      set_lane(0, 32'h1000, 7'd2, 1'b1, ITYPE_NONE);
      set_lane(1, 32'h1004, 7'd4, 1'b0, ITYPE_NTBR);
      valid_i = 2'b11;
      tick();
      valid_i = '0;
      for (int i = 0; i < 5; i++) begin
         n_chk++;
         if (blk_valid_o !== 1'b1 || blk.start !== 32'h1000 || blk.next !== 32'h1004) begin
            n_fail++; $display("FAIL hold_%0d: v=%b s=%h n=%h want 1/1000/1004", i, blk_valid_o, blk.start, blk.next);
         end
         tick();
      end
      blk_ready_i = 1'b1;
      tick();
      n_chk++;
      if (blk_valid_o !== 1'b1 || blk.start !== 32'h1004 || blk.itype !== ITYPE_NTBR || blk_cnt_o !== 32'd1) begin
         n_fail++; $display("FAIL lane1: v=%b s=%h t=%0d cnt=%0d want 1/1004/4/1", blk_valid_o, blk.start, blk.itype, blk_cnt_o);
      end
      tick();
      n_chk++;
      if (blk_valid_o !== 1'b0 || blk_cnt_o !== 32'd2 || seq_err_o !== 1'b0) begin
         n_fail++; $display("FAIL pair_done: v=%b cnt=%0d err=%b want 0/2/0", blk_valid_o, blk_cnt_o, seq_err_o);
      end
   endtask

   task automatic test_seq();
      logic [2:0] t0;
      for (int k = 0; k < 2; k++) begin
         t0 = (k == 0) ? ITYPE_NONE : ITYPE_TBR;
         do_reset();
         blk_ready_i = 1'b1;
         push_one(32'h0F0, 7'd8, 1'b0, t0);
         push_one(32'h104, 7'd1, 1'b0, ITYPE_NONE);
         tick();
         n_chk++;
         if (seq_err_o !== (k == 0)) begin
            n_fail++; $display("FAIL seq_itype%0d: err=%b want %b", t0, seq_err_o, (k == 0));
         end
      end
      do_reset();
      blk_ready_i = 1'b1;
      push_one(32'h0F0, 7'd8, 1'b0, ITYPE_NONE);
      push_one(32'h100, 7'd1, 1'b0, ITYPE_NONE);
      tick();
      n_chk++;
      if (seq_err_o !== 1'b0) begin
         n_fail++; $display("FAIL seq_match: err=%b want 0", seq_err_o);
      end
   endtask

   task automatic test_cause();
      do_reset();
      blk_ready_i = 1'b1;
      cause_i = 32'h2; tval_i = 32'hDEAD;
      push_one(32'h300, 7'd2, 1'b0, ITYPE_NONE);
      push_one(32'h2000, 7'd0, 1'b1, ITYPE_EXC);
      n_chk++;
      if (blk.empty !== 1'b1 || blk.start !== 32'h2000 || blk.last !== 32'h2000 || blk.next !== 32'h2000 ||
          blk.cause !== 32'h2 || blk.tval !== 32'hDEAD || blk.itype !== ITYPE_EXC) begin
         n_fail++; $display("FAIL empty_blk: e=%b s=%h l=%h n=%h c=%h tv=%h want 1/2000/2000/2000/2/dead",
                            blk.empty, blk.start, blk.last, blk.next, blk.cause, blk.tval);
      end
      // Tracker still expects 0x304, so a block at 0x2000 is a break.
      push_one(32'h2000, 7'd3, 1'b0, ITYPE_NONE);
      n_chk++;
      if (blk.cause !== '0 || blk.tval !== '0) begin
         n_fail++; $display("FAIL cause_mask: c=%h tv=%h want 0/0", blk.cause, blk.tval);
      end
      tick();
      n_chk++;
      if (seq_err_o !== 1'b1) begin
         n_fail++; $display("FAIL trk_unchanged: err=%b want 1", seq_err_o);
      end
   endtask

   task automatic test_overflow();
      int n;
      do_reset();
      blk_ready_i = 1'b1;
      push_one(32'h0F0, 7'd8, 1'b0, ITYPE_NONE);
      tick();
      blk_ready_i = 1'b0;
      for (int k = 0; k <= D; k++) push_one(32'h500 + 32'(4*k), 7'd2, 1'b0, ITYPE_NONE);
      n_chk++;
      if (overflow_o !== 1'b1 || blk_valid_o !== 1'b1 || blk.start !== 32'h500) begin
         n_fail++; $display("FAIL ovf_set: ovf=%b v=%b s=%h want 1/1/500", overflow_o, blk_valid_o, blk.start);
      end
      blk_ready_i = 1'b1;
      n = 0;
      while (blk_valid_o && n < 20) begin
         tick();
         n++;
      end
      n_chk++;
      if (n != D || blk_cnt_o !== 32'd9 || seq_err_o !== 1'b0) begin
         n_fail++; $display("FAIL ovf_drain: drained=%0d cnt=%0d err=%b want %0d/9/0", n, blk_cnt_o, seq_err_o, D);
      end
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      n_chk++;
      if (overflow_o !== 1'b0 || seq_err_o !== 1'b0 || blk_cnt_o !== 32'd0) begin
         n_fail++; $display("FAIL clear: ovf=%b err=%b cnt=%0d want 0/0/0", overflow_o, seq_err_o, blk_cnt_o);
      end
   endtask

   task automatic test_clear_priority();
      do_reset();
      blk_ready_i = 1'b1;
      push_one(32'h0F0, 7'd8, 1'b0, ITYPE_NONE);
      push_one(32'h104, 7'd1, 1'b0, ITYPE_NONE);
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      n_chk++;
      if (blk_cnt_o !== 32'd0 || seq_err_o !== 1'b1) begin
         n_fail++; $display("FAIL clear_prio: cnt=%0d err=%b want 0/1", blk_cnt_o, seq_err_o);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      blk_ready_i = 1'b1;
      set_lane(0, 32'h3000, 7'd2, 1'b1, ITYPE_NONE);
      set_lane(1, 32'h3004, 7'd2, 1'b1, ITYPE_NONE);
      valid_i = 2'b11;
      tick();
      valid_i = '0;
      tick();
      n_chk++;
      if (blk_valid_o !== 1'b1 || blk.start !== 32'h3004 || blk_cnt_o !== 32'd1) begin
         n_fail++; $display("FAIL mid_lane1: v=%b s=%h cnt=%0d want 1/3004/1", blk_valid_o, blk.start, blk_cnt_o);
      end
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      n_chk++;
      if (blk_valid_o !== 1'b0 || blk_cnt_o !== 32'd0 || seq_err_o !== 1'b0 || overflow_o !== 1'b0) begin
         n_fail++; $display("FAIL mid_rst: v=%b cnt=%0d err=%b ovf=%b want 0/0/0/0", blk_valid_o, blk_cnt_o, seq_err_o, overflow_o);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_chk++;
         if (blk_valid_o !== 1'b0 || blk_cnt_o !== 32'd0) begin
            n_fail++; $display("FAIL mid_after_%0d: v=%b cnt=%0d want 0/0", i, blk_valid_o, blk_cnt_o);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_seq();
      test_cause();
      test_overflow();
      test_clear_priority();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
